// File: rtl/cdb_issue_scheduler.sv
// cdb_issue_scheduler
//   Books common-data-bus slots for the fast issue queues, the pipelined multiplier
//   and the divider so that at most one result reaches the CDB in any cycle.
//   resv[k] = 1 means the CDB is already taken k+1 cycles from now; tag[k] records
//   the owner of that booking. Fast queues are arbitrated round-robin.
//   Optional feature macro: ISS_PERF_CNT_EN adds the Iss_StallCnt output, which counts
//   cycles where a fast queue was ready but lost its slot to a booking.
//   Handshake: each *_Rdy input is a level request held by the issuing queue; the matching
//   Iss_* grant is combinational in the same cycle, and the issue completes on the next
//   rising clk edge. A grant is never raised without its Rdy.
module cdb_issue_scheduler #(
  parameter int NUM_FAST = 2,
  parameter int MUL_LAT  = 4,
  parameter int DIV_LAT  = 7
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic [NUM_FAST-1:0] IssFast_Rdy,
  input  logic                IssMul_Rdy,
  input  logic                IssDiv_Rdy,
  input  logic                Div_ExeRdy,
  output logic [NUM_FAST-1:0] Iss_Fast,
  output logic                Iss_Mul,
  output logic                Iss_Div,
`ifdef ISS_PERF_CNT_EN
  output logic [15:0]         Iss_StallCnt,
`endif
  output logic [1:0]          Cdb_Owner
);

  localparam int RRW = (NUM_FAST > 1) ? $clog2(NUM_FAST) : 1;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_FAST = 2'd1;
  localparam logic [1:0] OWN_MUL  = 2'd2;
  localparam logic [1:0] OWN_DIV  = 2'd3;

  logic [DIV_LAT-1:0] resv;
  logic [DIV_LAT-1:0] resv_nxt;
  logic [1:0]         tag     [DIV_LAT];
  logic [1:0]         tag_nxt [DIV_LAT];
  logic [RRW-1:0]     rr_ptr;
  logic [RRW-1:0]     rr_nxt;
  logic [1:0]         own_q;
  logic [1:0]         own_nxt;
  logic               fast_any;

  // Mul and div look at different slots, so they never compete with each other.
  assign Iss_Div = resetb & IssDiv_Rdy & Div_ExeRdy & ~resv[DIV_LAT-1];
  assign Iss_Mul = resetb & IssMul_Rdy & ~resv[MUL_LAT-1];

  // Round-robin pick among fast queues, scanning upward from rr_ptr with wrap-around.
  always_comb begin
    Iss_Fast = '0;
    rr_nxt   = rr_ptr;
    fast_any = 1'b0;
    if (resetb && !resv[0]) begin
      for (int i = 0; i < NUM_FAST; i++) begin
        for (int j = 0; j < NUM_FAST; j++) begin
          if (!fast_any && IssFast_Rdy[j] && (((int'(rr_ptr) + i) % NUM_FAST) == j)) begin
            fast_any    = 1'b1;
            Iss_Fast[j] = 1'b1;
            rr_nxt      = RRW'((j + 1) % NUM_FAST);
          end
        end
      end
    end
  end

  // Advance the reservation window by one slot and add this cycle's new bookings.
  always_comb begin
    resv_nxt = resv >> 1;
    for (int k = 0; k < DIV_LAT - 1; k++) begin
      tag_nxt[k] = tag[k+1];
    end
    tag_nxt[DIV_LAT-1] = OWN_NONE;
    if (Iss_Div) begin
      resv_nxt[DIV_LAT-2] = 1'b1;
      tag_nxt[DIV_LAT-2]  = OWN_DIV;
    end
    if (Iss_Mul) begin
      resv_nxt[MUL_LAT-2] = 1'b1;
      tag_nxt[MUL_LAT-2]  = OWN_MUL;
    end
    // A fast issue only happens when slot 0 is free, so the two cases are exclusive.
    own_nxt = fast_any ? OWN_FAST : (resv[0] ? tag[0] : OWN_NONE);
  end

  // Scheduler state registers; reset drops every outstanding booking.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      resv   <= '0;
      rr_ptr <= '0;
      own_q  <= OWN_NONE;
      for (int k = 0; k < DIV_LAT; k++) begin
        tag[k] <= OWN_NONE;
      end
    end else begin
      resv   <= resv_nxt;
      rr_ptr <= rr_nxt;
      own_q  <= own_nxt;
      for (int k = 0; k < DIV_LAT; k++) begin
        tag[k] <= tag_nxt[k];
      end
    end
  end

  assign Cdb_Owner = own_q;

`ifdef ISS_PERF_CNT_EN
  logic [15:0] stall_cnt;

  // Saturating count of cycles where a ready fast queue was blocked by a booked slot.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      stall_cnt <= '0;
    end else if ((|IssFast_Rdy) && resv[0] && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign Iss_StallCnt = stall_cnt;
`endif

endmodule

// File: tb/tb_cdb_issue_scheduler.sv
// tb_cdb_issue_scheduler
//   Self-checking bench for cdb_issue_scheduler. The reference model keeps a calendar
//   of absolute CDB cycles (cycle number -> owner) and a round-robin pointer; grants are
//   derived from whether the target CDB cycle is already taken.
//   Build with +define+ISS_PERF_CNT_EN to also check Iss_StallCnt.
module tb_cdb_issue_scheduler;

  localparam int NUM_FAST = 2;
  localparam int MUL_LAT  = 4;
  localparam int DIV_LAT  = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetb = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_FAST-1:0] IssFast_Rdy = '0;
  logic                IssMul_Rdy  = 1'b0;
  logic                IssDiv_Rdy  = 1'b0;
  logic                Div_ExeRdy  = 1'b0;
  logic [NUM_FAST-1:0] Iss_Fast;
  logic                Iss_Mul;
  logic                Iss_Div;
  logic [1:0]          Cdb_Owner;
`ifdef ISS_PERF_CNT_EN
  logic [15:0]         Iss_StallCnt;
`endif

  cdb_issue_scheduler #(
    .NUM_FAST (NUM_FAST),
    .MUL_LAT  (MUL_LAT),
    .DIV_LAT  (DIV_LAT)
  ) dut (
    .clk          (clk),
    .resetb       (resetb),
    .IssFast_Rdy  (IssFast_Rdy),
    .IssMul_Rdy   (IssMul_Rdy),
    .IssDiv_Rdy   (IssDiv_Rdy),
    .Div_ExeRdy   (Div_ExeRdy),
    .Iss_Fast     (Iss_Fast),
    .Iss_Mul      (Iss_Mul),
    .Iss_Div      (Iss_Div),
`ifdef ISS_PERF_CNT_EN
    .Iss_StallCnt (Iss_StallCnt),
`endif
    .Cdb_Owner    (Cdb_Owner)
  );

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;   // cycles since reset release
  int cal [int];    // absolute CDB cycle -> owner (1 fast, 2 mul, 3 div)
  int rr_m   = 0;
  int stall_m = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: drive, check against the model, advance one cycle.
  task automatic step(input logic [NUM_FAST-1:0] f, input logic m, input logic d, input logic e);
    logic [NUM_FAST-1:0] exp_f;
    logic                exp_m;
    logic                exp_d;
    int                  own;
    int                  w;
    IssFast_Rdy = f;
    IssMul_Rdy  = m;
    IssDiv_Rdy  = d;
    Div_ExeRdy  = e;
    #1;
    exp_d = d && e && !cal.exists(cyc + DIV_LAT);
    exp_m = m && !cal.exists(cyc + MUL_LAT);
    exp_f = '0;
    if (!cal.exists(cyc + 1)) begin
      for (int i = 0; i < NUM_FAST; i++) begin
        w = (rr_m + i) % NUM_FAST;
        if (f[w]) begin
          exp_f[w] = 1'b1;
          rr_m = (w + 1) % NUM_FAST;
          break;
        end
      end
    end
    own = cal.exists(cyc) ? cal[cyc] : 0;
    check("iss_fast",  32'(Iss_Fast),  32'(exp_f));
    check("iss_mul",   32'(Iss_Mul),   32'(exp_m));
    check("iss_div",   32'(Iss_Div),   32'(exp_d));
    check("cdb_owner", 32'(Cdb_Owner), 32'(own));
`ifdef ISS_PERF_CNT_EN
    check("stall_cnt", 32'(Iss_StallCnt), 32'(stall_m));
    if ((|f) && cal.exists(cyc + 1) && stall_m < 65535) stall_m++;
`endif
    if (exp_d)  cal[cyc + DIV_LAT] = 3;
    if (exp_m)  cal[cyc + MUL_LAT] = 2;
    if (|exp_f) cal[cyc + 1] = 1;
    if (cal.exists(cyc)) cal.delete(cyc);
    cyc++;
    @(negedge clk);
  endtask

  // Holds reset for ncyc cycles with random requests; everything must stay quiet.
  task automatic do_reset(input int ncyc);
    resetb = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      IssFast_Rdy = NUM_FAST'($urandom);
      IssMul_Rdy  = 1'($urandom);
      IssDiv_Rdy  = 1'($urandom);
      Div_ExeRdy  = 1'($urandom);
      #1;
      check("rst_fast",  32'(Iss_Fast),  32'd0);
      check("rst_mul",   32'(Iss_Mul),   32'd0);
      check("rst_div",   32'(Iss_Div),   32'd0);
      check("rst_owner", 32'(Cdb_Owner), 32'd0);
`ifdef ISS_PERF_CNT_EN
      check("rst_stall", 32'(Iss_StallCnt), 32'd0);
`endif
      @(negedge clk);
    end
    IssFast_Rdy = '0;
    IssMul_Rdy  = 1'b0;
    IssDiv_Rdy  = 1'b0;
    Div_ExeRdy  = 1'b0;
    resetb  = 1'b1;
    cal.delete();
    cyc     = 0;
    rr_m    = 0;
    stall_m = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    do_reset(3);

    // Idle: no requests, no grants, bus stays empty.
    repeat (5) step('0, 1'b0, 1'b0, 1'b0);

    // Both fast queues ready: alternating grants, bus owned by fast.
    repeat (8) step(2'b11, 1'b0, 1'b0, 1'b0);

    // Multiplier pulse with fast queue 0 held: one fast bubble at MUL_LAT-1.
    step(2'b01, 1'b1, 1'b0, 1'b0);
    repeat (7) step(2'b01, 1'b0, 1'b0, 1'b0);

    // Divider then multiplier aimed at the same CDB cycle: mul slips by one.
    step('0, 1'b0, 1'b1, 1'b1);
    repeat (DIV_LAT - MUL_LAT - 1) step('0, 1'b0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0);
    repeat (8) step('0, 1'b0, 1'b0, 1'b0);

    // Divider busy, then idle: grant follows Div_ExeRdy in the same cycle.
    repeat (2) step('0, 1'b0, 1'b1, 1'b0);
    step('0, 1'b0, 1'b1, 1'b1);
    repeat (8) step('0, 1'b0, 1'b0, 1'b0);

    // Multiplier issued, then reset one cycle later: booking is discarded.
    step('0, 1'b1, 1'b0, 1'b0);
    do_reset(1);
    step(2'b01, 1'b0, 1'b0, 1'b0);
    repeat (6) step(2'b01, 1'b0, 1'b0, 1'b0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        step(NUM_FAST'($urandom),
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) != 0));
      end
    end

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
